// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, serial frame constants
// and a small sizing helper used by the arbiter blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam logic        UART_START_BIT  = 1'b0;
  localparam logic        UART_STOP_BIT   = 1'b1;
  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = UART_DATA_BITS + 2;

  // Width of an index into n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority selector: the first asserted request found
// scanning upward from ptr (wrapping) wins.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_req
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic           found;
  int unsigned    sum;

  // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    doubled   = {req, req} >> ptr;
    rotated   = doubled[N-1:0];
    found     = 1'b0;
    sum       = 0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        found = 1'b1;
        sum   = 32'(ptr) + i;
        if (sum >= N) sum = sum - N;
        grant_idx = W'(sum);
      end
    end
    any_req = |req;
    grant   = any_req ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources.
// A grant launches one frame; the arbiter then follows tx_busy up and down
// before reporting completion or a launch timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned BUSY_TIMEOUT = 8,
  localparam int unsigned GNT_W        = idx_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [GNT_W-1:0]     grant_id,
  output logic                 frame_done,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT) + 1;

  arb_state_t           state, state_n;
  logic [GNT_W-1:0]     rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [7:0]           tx_data_n;
  logic [GNT_W-1:0]     grant_id_n;
  logic                 tx_start_n, frame_done_n, timeout_err_n;
  logic [NUM_REQ-1:0]   req_ready_n;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [GNT_W-1:0]     arb_idx;
  logic                 arb_any;
  logic [7:0]           sel_byte;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Byte belonging to the current arbitration winner.
  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_byte = req_data[i*8 +: 8];
    end
  end

  // Next-state and next-output decode; pulses default low each cycle.
  always_comb begin
    state_n       = state;
    rr_ptr_n      = rr_ptr;
    cnt_n         = cnt;
    tx_data_n     = tx_data;
    grant_id_n    = grant_id;
    tx_start_n    = 1'b0;
    req_ready_n   = '0;
    frame_done_n  = 1'b0;
    timeout_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (arb_en && arb_any && !tx_busy) begin
          tx_start_n  = 1'b1;
          req_ready_n = arb_grant;
          tx_data_n   = sel_byte;
          grant_id_n  = arb_idx;
          rr_ptr_n    = (arb_idx == GNT_W'(NUM_REQ - 1)) ? '0 : arb_idx + GNT_W'(1);
          state_n     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else begin
          // Pulse on the edge where the count becomes BUSY_TIMEOUT-1, which
          // lands the error exactly BUSY_TIMEOUT cycles after tx_start.
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BUSY_TIMEOUT - 2)) begin
            timeout_err_n = 1'b1;
            state_n       = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          frame_done_n = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Registered outputs, round-robin pointer and busy-rise counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      cnt         <= '0;
      tx_data     <= '0;
      grant_id    <= '0;
      tx_start    <= 1'b0;
      req_ready   <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rr_ptr      <= rr_ptr_n;
      cnt         <= cnt_n;
      tx_data     <= tx_data_n;
      grant_id    <= grant_id_n;
      tx_start    <= tx_start_n;
      req_ready   <= req_ready_n;
      frame_done  <= frame_done_n;
      timeout_err <= timeout_err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        arb_en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        frame_done;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .arb_en      (arb_en),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transmitter model: 0 = normal, 1 = busy stuck low, 2 = busy stuck high.
  int unsigned busy_mode = 0;
  logic        mdl_busy = 1'b0;
  logic        serial = 1'b1;
  logic [9:0]  shreg = '0;
  logic [9:0]  line_log = '0;
  int unsigned bitn = 0;
  int unsigned baud_cnt = 0;

  always @(posedge clk) baud_cnt <= (baud_cnt == 15) ? 0 : baud_cnt + 1;

  always @(posedge clk) begin
    if (!mdl_busy) begin
      if (tx_start && busy_mode == 0) begin
        mdl_busy <= 1'b1;
        shreg    <= {1'b1, tx_data, 1'b0};
        bitn     <= 0;
      end
    end else if (baud_cnt == 15) begin
      if (bitn == 10) begin
        mdl_busy <= 1'b0;
        serial   <= 1'b1;
      end else begin
        serial         <= shreg[bitn];
        line_log[bitn] <= shreg[bitn];
        bitn           <= bitn + 1;
      end
    end
  end

  assign tx_busy = (busy_mode == 1) ? 1'b0 : (busy_mode == 2) ? 1'b1 : mdl_busy;

  // Output monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned start_cnt = 0, done_cnt = 0, tmo_cnt = 0;
  int unsigned start_cyc = 0, done_cyc = 0, tmo_cyc = 0, fall_cyc = 0;
  logic        prev_busy = 1'b0;
  logic [1:0]  gnt_log[$];
  logic [7:0]  data_log[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (tx_start) begin
      start_cnt++;
      start_cyc = cyc;
      gnt_log.push_back(grant_id);
      data_log.push_back(tx_data);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (timeout_err) begin
      tmo_cnt++;
      tmo_cyc = cyc;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc;
    prev_busy = tx_busy;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, input int unsigned budget);
    int unsigned n0 = start_cnt;
    int unsigned k = 0;
    while (start_cnt == n0 && k < budget) begin step(); k++; end
    if (start_cnt == n0) check({tag, " start_wait"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    int unsigned n0 = done_cnt;
    int unsigned k = 0;
    while (done_cnt == n0 && k < budget) begin step(); k++; end
    if (done_cnt == n0) check({tag, " done_wait"}, 0, 1);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // One request mask in, expected winner checked, then frame run to completion.
  task automatic run_frame(input logic [3:0] mask, input logic [1:0] exp_g, input string tag);
    req_valid = mask;
    wait_start(tag, 300);
    check({tag, " grant_id"}, 32'(grant_id), 32'(exp_g));
    check({tag, " req_ready"}, 32'(req_ready), 32'(4'b0001 << exp_g));
    req_valid = '0;
    wait_done(tag, 300);
  endtask

  int unsigned c0, s0, d0;

  initial begin
    rst = 1'b1; arb_en = 1'b0; req_valid = '0; req_data = '0;
    do_reset();

    // Reset state
    check("rst outputs", {20'd0, tx_start, req_ready, frame_done, timeout_err, grant_id, 2'd0},
          32'd0);
    check("rst tx_data", 32'(tx_data), 32'h0);

    // Single request from requester 2
    arb_en    = 1'b1;
    req_data  = 32'h44A52211;
    req_valid = 4'b0100;
    c0 = cyc;
    wait_start("single", 10);
    check("single latency", start_cyc - c0, 1);
    check("single req_ready", 32'(req_ready), 32'h4);
    check("single tx_data", 32'(tx_data), 32'hA5);
    check("single grant_id", 32'(grant_id), 2);
    req_valid = '0;
    wait_done("single", 300);
    check("single done after fall", done_cyc - fall_cyc, 1);
    check("single serial line", 32'(line_log), 32'h34A);
    check("single counts", {start_cnt[15:0], done_cnt[15:0]}, {16'd1, 16'd1});

    // All four requesters continuously valid
    do_reset();
    gnt_log.delete(); data_log.delete();
    s0 = start_cnt; d0 = done_cnt;
    req_data  = 32'h44332211;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) wait_start("rr", 300);
    req_valid = '0;
    wait_done("rr", 300);
    step();
    check("rr starts", start_cnt - s0, 5);
    check("rr dones", done_cnt - d0, 5);
    check("rr grants", {24'd0, gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 32'b00_01_10_11);
    check("rr wrap grant", 32'(gnt_log[4]), 0);
    check("rr bytes", {data_log[0], data_log[1], data_log[2], data_log[3]}, 32'h11223344);
    check("rr wrap byte", 32'(data_log[4]), 32'h11);

    // Pointer wrap: grant 2 leaves the pointer at 3
    do_reset();
    run_frame(4'b0100, 2, "ptr setup");
    run_frame(4'b1001, 3, "wrap 1001 a");
    run_frame(4'b0001, 0, "wrap 1001 b");
    do_reset();
    run_frame(4'b0100, 2, "ptr setup2");
    run_frame(4'b0001, 0, "wrap 0001");
    run_frame(4'b0011, 1, "ptr after wrap");

    // Timeout with tx_busy stuck low
    do_reset();
    busy_mode = 1;
    d0 = done_cnt;
    req_valid = 4'b0001;
    wait_start("tmo", 10);
    req_valid = '0;
    s0 = start_cyc;
    c0 = tmo_cnt;
    for (int k = 0; k < 20 && tmo_cnt == c0; k++) step();
    check("tmo pulse count", tmo_cnt - c0, 1);
    check("tmo distance", tmo_cyc - s0, 8);
    step();
    check("tmo pulse width", tmo_cnt - c0, 1);
    check("tmo no frame_done", done_cnt - d0, 0);
    req_valid = 4'b0010;
    c0 = cyc;
    wait_start("tmo idle", 5);
    check("tmo back in idle", start_cyc - c0, 1);
    check("tmo second grant", 32'(grant_id), 1);
    req_valid = '0;
    for (int k = 0; k < 12; k++) step();
    busy_mode = 0;

    // arb_en dropped mid-frame, then tx_busy forced high in idle
    do_reset();
    req_valid = 4'b1111;
    wait_start("en", 10);
    for (int k = 0; k < 20 && !tx_busy; k++) step();
    step();
    arb_en = 1'b0;
    d0 = done_cnt;
    wait_done("en", 300);
    check("en frame completes", done_cnt - d0, 1);
    s0 = start_cnt;
    for (int k = 0; k < 30; k++) step();
    check("en blocks grant", start_cnt - s0, 0);
    busy_mode = 2;
    arb_en = 1'b1;
    for (int k = 0; k < 30; k++) step();
    check("busy blocks grant", start_cnt - s0, 0);
    busy_mode = 0;
    wait_start("en resume", 5);
    check("en resume grant", 32'(grant_id), 1);
    req_valid = '0;
    wait_done("en resume", 300);

    // Asynchronous reset in the middle of a frame
    do_reset();
    run_frame(4'b0100, 2, "ar pre");
    req_valid = 4'b0100;
    wait_start("ar", 300);
    req_valid = '0;
    for (int k = 0; k < 40; k++) step();
    check("ar busy before rst", 32'(tx_busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar tx_data async", 32'(tx_data), 0);
    check("ar grant_id async", 32'(grant_id), 0);
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    wait_start("ar after", 300);
    check("ar restart from 0", 32'(grant_id), 0);
    req_valid = '0;
    wait_done("ar after", 300);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between NUM_REQ byte requesters using round-robin arbitration.
- Accepts a byte from the granted requester and issues a one-cycle tx_start with registered tx_data.
- Tracks tx_busy through its full rise/fall cycle, then reports frame completion.
- Sits between the requester logic (command/response sources) and the transmitter. The baud enable stays wired directly to the transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- BUSY_TIMEOUT, 8, cycles allowed for tx_busy to rise after tx_start before the frame is abandoned (≥2)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- arb_en  input  1  high = new grants allowed
- req_valid  input  NUM_REQ  per-requester byte-valid
- req_data  input  8*NUM_REQ  byte i on bits [8i+7:8i]
- req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester
- tx_start  output  1  one-cycle start pulse to the transmitter
- tx_data  output  8  byte to the transmitter, held until the next grant
- tx_busy  input  1  transmitter busy flag
- grant_id  output  GNT_W  index of the last granted requester; GNT_W = max(1, clog2(NUM_REQ))
- frame_done  output  1  one-cycle pulse when tx_busy falls after a grant
- timeout_err  output  1  one-cycle pulse when tx_busy failed to rise

Behaviour:
- One clock: clk. Reset is asynchronous and active-high on rst.
- All outputs are registered.
- Reset values:
  - outputs: tx_start=0, tx_data=0, req_ready=0, grant_id=0, frame_done=0, timeout_err=0
  - internal: state=IDLE, rr_ptr=0, timeout counter=0
  - Reset may be asserted mid-frame. It is not forwarded to the transmitter; that block has its own reset.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE, grant condition: arb_en=1, req_valid≠0 and tx_busy=0. When it holds:
  - Winner = first set req_valid bit scanning rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - Next cycle: tx_start=1, req_ready[winner]=1, tx_data=req_data[winner], grant_id=winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - Go to LAUNCH.
- IDLE, grant condition false: stay in IDLE; outputs hold except pulses, which clear.
- LAUNCH: tx_start=0 and req_ready=0 on the next edge. Clear the timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse timeout_err and return to IDLE without frame_done.
- WAIT_DONE: tx_busy=0 → pulse frame_done and go to IDLE.
- Pulse widths: tx_start and req_ready are exactly one cycle and coincident. frame_done and timeout_err are exactly one cycle.
- Gap between frames: at least one IDLE cycle between frame_done and the next tx_start.
- Requester contract:
  - Hold req_valid and req_data stable until req_ready is seen.
  - Deassert req_valid the cycle after req_ready if no further byte is pending.
  - Dropping req_valid before a grant is legal and has no effect.
- arb_en=0 blocks only new grants. A frame already in LAUNCH, WAIT_BUSY or WAIT_DONE completes normally.
- tx_busy=1 while in IDLE (external/foreign use) blocks grants. No error is raised.
- A req_valid change during LAUNCH, WAIT_BUSY or WAIT_DONE is ignored until IDLE.
- NUM_REQ=1: rr_ptr is constant 0 and the single requester is always the winner.

Decomposition:
- Shared package uart_pkg holds:
  - arbiter state encodings (2-bit IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3)
  - the UART frame constants (START=0, STOP=1, DATA_BITS=8)
- One sub-module, rr_arbiter: purely combinational rotate-priority select.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Reusable by future RX-side or multi-UART schedulers.

Test Plan:
- Single request: req_valid=4'b0100 with req_data byte 2=8'hA5, transmitter attached, baud enable every 16 cycles:
  - tx_start and req_ready[2] pulse together one cycle after the request.
  - tx_data=8'hA5 and grant_id=2.
  - frame_done pulses one cycle after tx_busy falls. Serial line shows 0,1,0,1,0,0,1,0,1,1.
- All four requesters continuously valid with bytes 11/22/33/44:
  - grant order 0,1,2,3,0.
  - exactly one tx_start per frame_done.
- Pointer wrap: rr_ptr=3 with req_valid=4'b1001 → grants 3 then 0. rr_ptr=3 with req_valid=4'b0001 → grant 0 and rr_ptr=1.
- Timeout: tx_busy tied 0, single request → timeout_err pulses exactly BUSY_TIMEOUT cycles after tx_start, state back to IDLE, no frame_done.
- arb_en deasserted during WAIT_DONE with pending requests → current frame_done still pulses, then no tx_start until arb_en=1. tx_busy forced 1 in IDLE also blocks grants.
- rst asserted asynchronously mid-WAIT_DONE → all outputs at reset values immediately without waiting for clk. After release, arbitration starts from requester 0.
